branch_ctrl: RTL
================

// Module: branch_ctrl
// PURPOSE
//  Sequences conditional-branch resolution between execute and fetch: accepts one branch, compares operands,
//  detects misprediction, drives a redirect handshake to fetch, then a bounded pipeline flush.
//  Keeps branch/mispredict statistics; optionally hosts a 2-bit branch history table for fetch prediction.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush is held after redirect accepted (>=1)
//  CNT_W         32  width of statistics counters
//  BHT_BITS      6   log2 BHT entries (used only with BRANCH_CTRL_BHT_EN)
// PORTS
//  clock          in   1       sole clock, rising edge
//  reset          in   1       synchronous, active-high
//  br_valid       in   1       branch offered by execute
//  br_ready       out  1       controller can accept (IDLE only)
//  br_op          in   6       one-hot {bgeu,bltu,bge,blt,bne,beq}
//  br_pc          in   32      branch PC
//  br_imm         in   32      sign-extended offset
//  rdata1/rdata2  in   32      operands
//  br_pred        in   1       taken-prediction fetch made for this branch
//  redirect_valid out  1       redirect request to fetch
//  redirect_ready in   1       fetch accepts redirect
//  redirect_pc    out  32      corrected PC
//  flush          out  1       kill younger instructions
//  resolve_done   out  1       one-cycle pulse: branch retired from controller
//  fetch_pc       in   32      BHT lookup address
//  fetch_pred     out  1       BHT prediction (0 without macro)
//  cnt_branch     out  CNT_W   branches resolved
//  cnt_mispred    out  CNT_W   mispredictions
// BEHAVIOUR
//  Reset: state IDLE; br_ready=1; redirect_valid, flush, resolve_done=0; redirect_pc=0; counters=0.
//  Accept on br_valid&br_ready: register op, pc, imm, operands, pred; go RESOLVE.
//  RESOLVE (1 cycle): taken by op priority beq>bne>blt>bge>bltu>bgeu; blt/bge signed, bltu/bgeu unsigned;
//   zero op -> not taken. target = taken ? pc+imm : pc+4, 32-bit wrap, no overflow flag.
//   cnt_branch++; if taken!=pred: cnt_mispred++, go REDIRECT; else resolve_done=1 next cycle, go IDLE.
//  REDIRECT: redirect_valid=1, redirect_pc stable until redirect_ready sampled 1; then FLUSH.
//  FLUSH: flush=1 for exactly FLUSH_CYCLES cycles; last cycle -> IDLE with resolve_done pulse next cycle.
//  Latency: correct prediction 2 cycles accept->resolve_done; mispredict 2 + wait + FLUSH_CYCLES + 1.
//  br_ready=0 outside IDLE; br_valid there is ignored and must be held by execute.
//  br_ready comb from state; redirect_valid/flush/resolve_done registered.
//  Counters wrap modulo 2^CNT_W, both increment same cycle if needed.
//  Reset mid-operation: abandon branch, no redirect, counters cleared.
// CONFIGURATION
//  BRANCH_CTRL_BHT_EN defined: 2^BHT_BITS 2-bit saturating counters, index pc[BHT_BITS+1:2], reset 2'b01.
//   fetch_pred = ctr[idx(fetch_pc)][1], combinational. Updated in RESOLVE: taken ++ (sat 11), else -- (sat 00).
//   Lookup same index as update cycle returns pre-update value.
//  Undefined: no table, fetch_pred tied 0; controller otherwise identical.
// STRUCTURE
//  Shared package wires: branch_ctrl_state_type enum {IDLE,RESOLVE,REDIRECT,FLUSH},
//   bcu_op-style one-hot op struct, branch_ctrl_in_type/branch_ctrl_out_type, BHT_INIT constant.
//  One sub-module: bht_table (counter array, lookup/update ports), instantiated only under macro.
// TESTING
//  beq 5==5, pred=1 -> no redirect, resolve_done at cycle 2, cnt_branch=1, cnt_mispred=0.
//  blt -1 vs 1 pc=0x100 imm=0x40 pred=0 -> redirect_pc=0x140, flush 2 cycles, cnt_mispred=1.
//  bltu 0xFFFFFFFF vs 1 pred=1 -> not taken, redirect_pc=pc+4; pc=0xFFFFFFFC -> redirect_pc=0.
//  redirect_ready low 5 cycles -> redirect_valid/pc held, flush only after accept; br_ready=0 throughout.
//  reset asserted in FLUSH -> next cycle IDLE, flush=0, counters 0, br_ready=1.
//  BHT_EN: 3 taken at pc=0x200 -> fetch_pred(0x200)=1; 3 not-taken -> 0; aliasing pc=0x300 same entry.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared types for the branch controller: FSM states, one-hot op decode,
// captured-branch and resolve-result structs, BHT reset value, resolve helper.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT, FLUSH} branch_ctrl_state_type;

  // Field order matches the one-hot bus {bgeu,bltu,bge,blt,bne,beq}; beq is bit 0.
  typedef struct packed {
    logic bgeu;
    logic bltu;
    logic bge;
    logic blt;
    logic bne;
    logic beq;
  } bcu_op_type;

  typedef struct packed {
    bcu_op_type  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
  } branch_ctrl_in_type;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } branch_ctrl_out_type;

  localparam logic [1:0] BHT_INIT = 2'b01;

  function automatic branch_ctrl_out_type bcu_resolve(input branch_ctrl_in_type r);
    branch_ctrl_out_type o;
    logic t;
    t = 1'b0;
    if (r.op.beq)       t = (r.rs1 == r.rs2);
    else if (r.op.bne)  t = (r.rs1 != r.rs2);
    else if (r.op.blt)  t = ($signed(r.rs1) <  $signed(r.rs2));
    else if (r.op.bge)  t = ($signed(r.rs1) >= $signed(r.rs2));
    else if (r.op.bltu) t = (r.rs1 <  r.rs2);
    else if (r.op.bgeu) t = (r.rs1 >= r.rs2);
    o.taken  = t;
    o.target = t ? (r.pc + r.imm) : (r.pc + 32'd4);
    return o;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Execute/fetch-facing bundle of the branch controller; slave = controller side.
interface branch_ctrl_if #(parameter int CNT_W = 32);
  logic             br_valid;
  logic             br_ready;
  logic [5:0]       br_op;
  logic [31:0]      br_pc;
  logic [31:0]      br_imm;
  logic [31:0]      rdata1;
  logic [31:0]      rdata2;
  logic             br_pred;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             resolve_done;
  logic [31:0]      fetch_pc;
  logic             fetch_pred;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_mispred;

  modport master (
    output br_valid, br_op, br_pc, br_imm, rdata1, rdata2, br_pred, redirect_ready, fetch_pc,
    input  br_ready, redirect_valid, redirect_pc, flush, resolve_done, fetch_pred,
           cnt_branch, cnt_mispred
  );

  modport slave (
    input  br_valid, br_op, br_pc, br_imm, rdata1, rdata2, br_pred, redirect_ready, fetch_pc,
    output br_ready, redirect_valid, redirect_pc, flush, resolve_done, fetch_pred,
           cnt_branch, cnt_mispred
  );
endinterface

// File: rtl/branch_ctrl_bht.sv
// Branch history table: 2^BHT_BITS two-bit saturating counters indexed by pc[BHT_BITS+1:2].
// Lookup is combinational and sees the pre-update value during an update cycle.
module bht_table
  import branch_ctrl_pkg::*;
#(
  parameter int BHT_BITS = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lookup_pc_i,
  output logic        lookup_pred_o,
  input  logic        upd_en_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i
);
  localparam int N = 1 << BHT_BITS;

  logic [N-1:0][1:0]    ctr_q;
  logic [BHT_BITS-1:0]  lidx, uidx;
  logic                 unused_pc_bits;

  assign lidx           = lookup_pc_i[BHT_BITS+1:2];
  assign uidx           = upd_pc_i[BHT_BITS+1:2];
  assign lookup_pred_o  = ctr_q[lidx][1];
  assign unused_pc_bits = ^{lookup_pc_i[31:BHT_BITS+2], lookup_pc_i[1:0],
                            upd_pc_i[31:BHT_BITS+2], upd_pc_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctr_q <= {N{BHT_INIT}};
    end else if (upd_en_i) begin
      if (upd_taken_i && ctr_q[uidx] != 2'b11)
        ctr_q[uidx] <= ctr_q[uidx] + 2'd1;
      else if (!upd_taken_i && ctr_q[uidx] != 2'b00)
        ctr_q[uidx] <= ctr_q[uidx] - 2'd1;
    end
  end
endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: accept -> resolve -> (redirect -> flush) -> done.
// Define BRANCH_CTRL_BHT_EN to host the 2-bit branch history table for fetch prediction.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32,
  parameter int BHT_BITS     = 6
) (
  input logic         clock,
  input logic         reset,
  branch_ctrl_if.slave bus
);
  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

  branch_ctrl_state_type state_q, state_d;
  branch_ctrl_in_type    req_q, req_d;
  branch_ctrl_out_type   res;
  logic                  redirect_valid_q, redirect_valid_d;
  logic                  flush_q, flush_d;
  logic                  resolve_done_q, resolve_done_d;
  logic [31:0]           redirect_pc_q, redirect_pc_d;
  logic [FC_W-1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0]      cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0]      cnt_mispred_q, cnt_mispred_d;

  assign res = bcu_resolve(req_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      req_q            <= '0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      resolve_done_q   <= 1'b0;
      redirect_pc_q    <= '0;
      fcnt_q           <= '0;
      cnt_branch_q     <= '0;
      cnt_mispred_q    <= '0;
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      resolve_done_q   <= resolve_done_d;
      redirect_pc_q    <= redirect_pc_d;
      fcnt_q           <= fcnt_d;
      cnt_branch_q     <= cnt_branch_d;
      cnt_mispred_q    <= cnt_mispred_d;
    end
  end

  // Output registers are loaded with the value they must show in the next state.
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    redirect_valid_d = 1'b0;
    flush_d          = 1'b0;
    resolve_done_d   = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    fcnt_d           = fcnt_q;
    cnt_branch_d     = cnt_branch_q;
    cnt_mispred_d    = cnt_mispred_q;
    case (state_q)
      IDLE: begin
        if (bus.br_valid) begin
          req_d.op   = bcu_op_type'(bus.br_op);
          req_d.pc   = bus.br_pc;
          req_d.imm  = bus.br_imm;
          req_d.rs1  = bus.rdata1;
          req_d.rs2  = bus.rdata2;
          req_d.pred = bus.br_pred;
          state_d    = RESOLVE;
        end
      end
      RESOLVE: begin
        cnt_branch_d = cnt_branch_q + CNT_W'(1);
        if (res.taken != req_q.pred) begin
          cnt_mispred_d    = cnt_mispred_q + CNT_W'(1);
          redirect_pc_d    = res.target;
          redirect_valid_d = 1'b1;
          state_d          = REDIRECT;
        end else begin
          resolve_done_d = 1'b1;
          state_d        = IDLE;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          flush_d = 1'b1;
          fcnt_d  = '0;
          state_d = FLUSH;
        end else begin
          redirect_valid_d = 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
          resolve_done_d = 1'b1;
          state_d        = IDLE;
        end else begin
          flush_d = 1'b1;
          fcnt_d  = fcnt_q + FC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.br_ready       = (state_q == IDLE);
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.resolve_done   = resolve_done_q;
  assign bus.cnt_branch     = cnt_branch_q;
  assign bus.cnt_mispred    = cnt_mispred_q;

`ifdef BRANCH_CTRL_BHT_EN
  bht_table #(.BHT_BITS(BHT_BITS)) u_bht (
    .clk_i        (clock),
    .rst_i        (reset),
    .lookup_pc_i  (bus.fetch_pc),
    .lookup_pred_o(bus.fetch_pred),
    .upd_en_i     (state_q == RESOLVE),
    .upd_pc_i     (req_q.pc),
    .upd_taken_i  (res.taken)
  );
`else
  logic unused_fetch;
  assign unused_fetch   = ^{bus.fetch_pc, BHT_BITS[0]};
  assign bus.fetch_pred = 1'b0;
`endif
endmodule
